// File: rtl/leb128_encoder.sv
// Streaming LEB128 encoder: one 64-bit value in, its ULEB/SLEB byte sequence out.
// Two-state FSM (IDLE accepts, EMIT streams bytes); every output decodes from registered state.
module leb128_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_value,
  input  logic        in_signed,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  out_index,
  output logic        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // A producer holds its payload stable while valid & ~ready; ready never depends on valid.

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] sr_q, sr_d;
  logic        signed_q, signed_d;
  logic [3:0]  idx_q, idx_d;
  logic        more;

  // Signed stops once the remaining bits are a pure sign extension of bit 6.
  always_comb begin
    if (signed_q) more = !((sr_q[63:6] == '0) || (sr_q[63:6] == '1));
    else          more = (sr_q[63:7] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    out_index = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d     = in_value;
          signed_d = in_signed;
          idx_d    = 4'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_byte  = {more, sr_q[6:0]};
        out_last  = ~more;
        out_index = idx_q;
        if (out_ready) begin
          if (more) begin
            sr_d  = {{7{signed_q & sr_q[63]}}, sr_q[63:7]};
            idx_d = idx_q + 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_leb128_encoder.sv
// Directed bench for leb128_encoder: hand-computed byte streams, backpressure,
// mid-sequence reset and back-to-back values, checked against an expected-byte queue.
module tb_leb128_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_value;
  logic        in_signed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  out_index;
  logic        dbg_state;

  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [5:0]  rdy_pat  = 6'b101001;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  leb128_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_value  (in_value),
    .in_signed (in_signed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  // Offer a value starting at a negedge; optionally keep in_valid high with the next value.
  task automatic accept(input string tag, input logic [63:0] v, input logic s,
                        input logic keep, input logic [63:0] nv, input logic ns);
    int g = 0;
    in_value  = v;
    in_signed = s;
    in_valid  = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    if (keep) begin
      in_value  = nv;
      in_signed = ns;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Consume exp_q, checking every cycle in EMIT; ends at the negedge of the idle bubble.
  task automatic drain(input string tag, input logic stall);
    int idx = 0;
    int c   = 0;
    while (exp_q.size() > 0 && c < 100) begin
      @(negedge clk);
      out_ready = stall ? rdy_pat[c % 6] : 1'b1;
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " out_byte"},  out_byte, exp_q[0]);
      check({tag, " out_index"}, out_index, idx);
      check({tag, " out_last"},  out_last, (exp_q.size() == 1));
      check({tag, " in_ready_emit"}, in_ready, 0);
      check({tag, " dbg_state"}, dbg_state, 1);
      if (out_ready) begin
        void'(exp_q.pop_front());
        idx++;
      end
      c++;
    end
    check({tag, " drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, " idle out_valid"}, out_valid, 0);
    check({tag, " idle in_ready"}, in_ready, 1);
    check({tag, " idle out_last"}, out_last, 0);
  endtask

  task automatic encode(input string tag, input logic [63:0] v, input logic s, input logic [7:0] b[$]);
    push_bytes(b);
    accept(tag, v, s, 1'b0, 64'd0, 1'b0);
    drain(tag, 1'b0);
  endtask

  initial begin
    logic [7:0] b[$];
    reset     = 1'b1;
    in_value  = 64'd0;
    in_signed = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst in_ready",  in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_byte",  out_byte, 0);
    check("rst out_last",  out_last, 0);
    check("rst out_index", out_index, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 64'd5;
    repeat (2) @(negedge clk);
    check("rst ignore in_valid", out_valid, 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("post-rst out_valid", out_valid, 0);
    check("post-rst in_ready",  in_ready, 1);
    check("post-rst out_index", out_index, 0);

    // Unsigned / signed directed vectors
    b = '{8'h00};                encode("u0", 64'd0, 1'b0, b);
    b = '{8'hE5, 8'h8E, 8'h26};  encode("u624485", 64'd624485, 1'b0, b);
    b = '{8'hC0, 8'hBB, 8'h78};  encode("s-123456", -64'sd123456, 1'b1, b);
    b = '{8'h3F};                encode("s63", 64'd63, 1'b1, b);
    b = '{8'hC0, 8'h00};         encode("s64", 64'd64, 1'b1, b);
    b = '{8'h40};                encode("s-64", -64'sd64, 1'b1, b);
    b = '{8'hBF, 8'h7F};         encode("s-65", -64'sd65, 1'b1, b);
    b = '{8'h7F};                encode("s-1", -64'sd1, 1'b1, b);
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    encode("umax", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, b);
    b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
    encode("smin", 64'h8000_0000_0000_0000, 1'b1, b);

    // Backpressure with a second value held on the input during EMIT
    b = '{8'hE5, 8'h8E, 8'h26};
    push_bytes(b);
    accept("bp", 64'd624485, 1'b0, 1'b1, 64'd42, 1'b0);
    drain("bp", 1'b1);
    b = '{8'h2A};
    push_bytes(b);
    accept("bp-held", 64'd42, 1'b0, 1'b0, 64'd0, 1'b0);
    drain("bp-held", 1'b0);

    // Reset in the middle of unsigned 2^63
    accept("rst-mid", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("rst-mid first byte", out_byte, 8'h80);
    @(posedge clk);
    #1;
    check("rst-mid second index", out_index, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst-mid out_valid", out_valid, 0);
    check("rst-mid in_ready",  in_ready, 1);
    check("rst-mid out_index", out_index, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst-mid released out_valid", out_valid, 0);
    b = '{8'h2A};
    encode("after-rst 42", 64'd42, 1'b0, b);

    // Back-to-back 1, 300, -2 with in_valid held
    b = '{8'h01};
    push_bytes(b);
    accept("b2b 1", 64'd1, 1'b0, 1'b1, 64'd300, 1'b0);
    drain("b2b 1", 1'b0);
    b = '{8'hAC, 8'h02};
    push_bytes(b);
    accept("b2b 300", 64'd300, 1'b0, 1'b1, -64'sd2, 1'b1);
    drain("b2b 300", 1'b0);
    b = '{8'h7E};
    push_bytes(b);
    accept("b2b -2", -64'sd2, 1'b1, 1'b0, 64'd0, 1'b0);
    drain("b2b -2", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
